led_pattern_engine: RTL and testbench



---
 rtl/led_pattern_pkg.sv | 28 ++
 rtl/led_pwm_bank.sv | 54 +++++
 rtl/led_pattern_engine.sv | 176 +++++++++++++++++
 tb/tb_led_pattern_engine.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared mode/direction types and the ring preload helper
// for led_pattern_engine.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        ROTATE  = 2'd0,
        BOUNCE  = 2'd1,
        BREATHE = 2'd2,
        STATIC  = 2'd3
    } mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    // n = channel count, w = duty width; result is truncated by the caller
    function automatic int preload(int i, mode_t m, int n, int w);
        int full;
        full = (1 << w) - 1;
        unique case (m)
            BOUNCE:  preload = (i == 0) ? full : 0;
            BREATHE: preload = 0;
            default: preload = ((i * (1 << w)) / n) & full;
        endcase
    endfunction

endpackage

// File: rtl/led_pwm_bank.sv
// led_pwm_bank: shared PWM counter and per-channel comparators.
// LED_PATTERN_GAMMA_EN adds a registered square-law gamma map (2-clock latency).
module led_pwm_bank #(
    parameter int N_LEDS = 16,
    parameter int PWM_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_LEDS*PWM_W-1:0] duty,
    output logic [N_LEDS-1:0]       led
);

    logic [PWM_W-1:0]        pwm_cnt;
    logic [N_LEDS*PWM_W-1:0] eff_duty;

`ifdef LED_PATTERN_GAMMA_EN
    for (genvar g = 0; g < N_LEDS; g++) begin : g_gamma
        logic [PWM_W-1:0]   d;
        logic [2*PWM_W-1:0] sq;
        logic [PWM_W-1:0]   g_q;

        assign d  = duty[g*PWM_W +: PWM_W];
        assign sq = {{PWM_W{1'b0}}, d} * {{PWM_W{1'b0}}, d};

        // nonzero duty never maps to fully off
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                g_q <= '0;
            end else if (d != '0 && sq[2*PWM_W-1:PWM_W] == '0) begin
                g_q <= PWM_W'(1);
            end else begin
                g_q <= sq[2*PWM_W-1:PWM_W];
            end
        end

        assign eff_duty[g*PWM_W +: PWM_W] = g_q;
    end
`else
    assign eff_duty = duty;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            for (int i = 0; i < N_LEDS; i++) begin
                led[i] <= pwm_cnt < eff_duty[i*PWM_W +: PWM_W];
            end
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: PWM LED ring with rotate/bounce/breathe/static modes,
// speed select, pause/step. Gamma option: LED_PATTERN_GAMMA_EN (in led_pwm_bank).
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int N_LEDS        = 16,
    parameter int PWM_W         = 6,
    parameter int N_SPEEDS      = 5,
    parameter int TICK_W        = 24,
    parameter int BASE_INTERVAL = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_SPEEDS-1:0] speed_btn,
    input  logic                mode_btn,
    input  logic                pause_btn,
    input  logic                step_btn,
    output logic [N_LEDS-1:0]   led,
    output logic [1:0]          mode,
    output logic                running
);

    localparam int SEL_W = (N_SPEEDS > 1) ? $clog2(N_SPEEDS) : 1;
    localparam logic [PWM_W-1:0] FULL = '1;

    logic [2:0]              btn_cur;
    logic [2:0]              btn_prev;
    logic [2:0]              rise;
    logic                    mode_rise;
    logic                    pause_rise;
    logic                    step_rise;
    logic [SEL_W-1:0]        speed_sel;
    logic [SEL_W-1:0]        sel_idx;
    logic [TICK_W-1:0]       interval;
    logic [TICK_W-1:0]       next_interval;
    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick_hit;
    logic                    step_req;
    logic                    step_pulse;
    mode_t                   mode_q;
    mode_t                   mode_next;
    dir_t                    dir;
    logic [PWM_W-1:0]        level;
    logic [PWM_W-1:0]        level_next;
    logic [PWM_W-1:0]        duty [N_LEDS];
    logic [N_LEDS*PWM_W-1:0] duty_flat;

    assign rise       = btn_cur & ~btn_prev;
    assign mode_rise  = rise[0];
    assign pause_rise = rise[1];
    assign step_rise  = rise[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_cur  <= '0;
            btn_prev <= '0;
        end else begin
            btn_cur  <= {step_btn, pause_btn, mode_btn};
            btn_prev <= btn_cur;
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < N_SPEEDS; k++) begin
            if (speed_btn[k]) sel_idx = SEL_W'(k);
        end
    end

    assign next_interval =
        TICK_W'(BASE_INTERVAL * (int'(speed_sel) + 1) - 1);
    assign tick_hit   = running && (tick_cnt == interval);
    assign step_pulse = tick_hit | step_req;

    // interval only reloads at a wrap, so the counter is never restarted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_sel <= SEL_W'(N_SPEEDS - 1);
            interval  <= TICK_W'(BASE_INTERVAL * N_SPEEDS - 1);
            tick_cnt  <= '0;
            step_req  <= 1'b0;
            running   <= 1'b1;
        end else begin
            if ($onehot(speed_btn)) speed_sel <= sel_idx;
            if (pause_rise) running <= ~running;
            step_req <= step_rise & ~running;
            if (running) begin
                if (tick_hit) begin
                    tick_cnt <= '0;
                    interval <= next_interval;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= ROTATE;
        else        mode_q <= mode_next;
    end

    always_comb begin
        mode_next = mode_q;
        if (mode_rise) begin
            unique case (mode_q)
                ROTATE:  mode_next = BOUNCE;
                BOUNCE:  mode_next = BREATHE;
                BREATHE: mode_next = STATIC;
                STATIC:  mode_next = ROTATE;
            endcase
        end
    end

    assign level_next = (dir == UP) ? level + 1'b1 : level - 1'b1;

    // a mode change takes priority over a coincident step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LEDS; i++) begin
                duty[i] <= PWM_W'(preload(i, ROTATE, N_LEDS, PWM_W));
            end
            dir   <= UP;
            level <= '0;
        end else if (mode_rise) begin
            for (int i = 0; i < N_LEDS; i++) begin
                duty[i] <= PWM_W'(preload(i, mode_next, N_LEDS, PWM_W));
            end
            dir   <= UP;
            level <= '0;
        end else if (step_pulse) begin
            unique case (mode_q)
                ROTATE: begin
                    for (int i = 1; i < N_LEDS; i++) duty[i] <= duty[i-1];
                    duty[0] <= duty[N_LEDS-1];
                end
                BOUNCE: begin
                    if (dir == UP) begin
                        for (int i = 1; i < N_LEDS; i++) duty[i] <= duty[i-1];
                        duty[0] <= duty[N_LEDS-1];
                        if (duty[N_LEDS-2] != '0) dir <= DOWN;
                    end else begin
                        for (int i = 0; i < N_LEDS-1; i++) duty[i] <= duty[i+1];
                        duty[N_LEDS-1] <= duty[0];
                        if (duty[1] != '0) dir <= UP;
                    end
                end
                BREATHE: begin
                    level <= level_next;
                    for (int i = 0; i < N_LEDS; i++) duty[i] <= level_next;
                    if (level_next == FULL)    dir <= DOWN;
                    else if (level_next == '0) dir <= UP;
                end
                STATIC: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_LEDS; g++) begin : g_flat
        assign duty_flat[g*PWM_W +: PWM_W] = duty[g];
    end

    led_pwm_bank #(
        .N_LEDS (N_LEDS),
        .PWM_W  (PWM_W)
    ) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_flat),
        .led   (led)
    );

    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed checks on a 16x6-bit and a 4x3-bit
// instance sharing one set of button inputs.
module tb_led_pattern_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  speed_btn = '0;
    logic        mode_btn = 1'b0;
    logic        pause_btn = 1'b0;
    logic        step_btn = 1'b0;
    logic [15:0] led_a;
    logic [1:0]  mode_a;
    logic        run_a;
    logic [3:0]  led_b;
    logic [1:0]  mode_b;
    logic        run_b;
    int          checks = 0;
    int          errors = 0;
    int          save_cnt;

    always #5 clk = ~clk;

    led_pattern_engine #(
        .N_LEDS(16), .PWM_W(6), .N_SPEEDS(5),
        .TICK_W(24), .BASE_INTERVAL(10)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .speed_btn(speed_btn),
        .mode_btn(mode_btn), .pause_btn(pause_btn), .step_btn(step_btn),
        .led(led_a), .mode(mode_a), .running(run_a)
    );

    led_pattern_engine #(
        .N_LEDS(4), .PWM_W(3), .N_SPEEDS(5),
        .TICK_W(24), .BASE_INTERVAL(10)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .speed_btn(speed_btn),
        .mode_btn(mode_btn), .pause_btn(pause_btn), .step_btn(step_btn),
        .led(led_b), .mode(mode_b), .running(run_b)
    );

    // which: 0 mode, 1 pause, 2 step; called and returns at posedge+1
    task automatic press(input int which);
        if (which == 0) mode_btn = 1'b1;
        else if (which == 1) pause_btn = 1'b1;
        else step_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mode_btn  = 1'b0;
        pause_btn = 1'b0;
        step_btn  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic measure_a(input int ch, output int hi);
        hi = 0;
        repeat (64) begin
            @(negedge clk);
            if (led_a[ch]) hi = hi + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic measure_b(input int ch, output int hi);
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (led_b[ch]) hi = hi + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pattern_b(output logic [3:0] pat);
        pat = '0;
        repeat (8) begin
            @(negedge clk);
            pat = pat | led_b;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gap(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (!u_a.step_pulse && n < 200);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (led_a !== 16'h0) begin
            errors++;
            $display("FAIL rst_led_a got %h want 0000", led_a);
        end
        checks++;
        if (led_b !== 4'h0) begin
            errors++;
            $display("FAIL rst_led_b got %h want 0", led_b);
        end
        checks++;
        if (mode_a !== 2'd0) begin
            errors++;
            $display("FAIL rst_mode got %0d want 0", mode_a);
        end
        checks++;
        if (run_a !== 1'b1 || run_b !== 1'b1) begin
            errors++;
            $display("FAIL rst_running got %b%b want 11", run_a, run_b);
        end
        checks++;
        if (u_a.tick_cnt !== 24'd0) begin
            errors++;
            $display("FAIL rst_tick got %0d want 0", u_a.tick_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rotate();
        int hi;
        press(1);
        checks++;
        if (run_a !== 1'b0) begin
            errors++;
            $display("FAIL rot_paused got %b want 0", run_a);
        end
        measure_a(15, hi);
        checks++;
        if (hi !== 60) begin
            errors++;
            $display("FAIL rot_led15_high got %0d want 60", hi);
        end
        measure_a(1, hi);
        checks++;
        if (hi !== 4) begin
            errors++;
            $display("FAIL rot_led1_high got %0d want 4", hi);
        end
        press(2);
        measure_a(0, hi);
        checks++;
        if (hi !== 60) begin
            errors++;
            $display("FAIL rot_step_led0 got %0d want 60", hi);
        end
        measure_a(1, hi);
        checks++;
        if (hi !== 0) begin
            errors++;
            $display("FAIL rot_step_led1 got %0d want 0", hi);
        end
        measure_b(0, hi);
        checks++;
        if (hi !== 6) begin
            errors++;
            $display("FAIL rot_step_b0 got %0d want 6", hi);
        end
    endtask

    task automatic test_pause_step();
        int hi;
        save_cnt = int'(u_a.tick_cnt);
        repeat (3) press(2);
        measure_a(0, hi);
        checks++;
        if (hi !== 48) begin
            errors++;
            $display("FAIL step3_led0 got %0d want 48", hi);
        end
        measure_a(4, hi);
        checks++;
        if (hi !== 0) begin
            errors++;
            $display("FAIL step3_led4 got %0d want 0", hi);
        end
        measure_b(3, hi);
        checks++;
        if (hi !== 6) begin
            errors++;
            $display("FAIL step3_b3 got %0d want 6", hi);
        end
        checks++;
        if (int'(u_a.tick_cnt) !== save_cnt) begin
            errors++;
            $display("FAIL pause_frozen got %0d want %0d",
                     u_a.tick_cnt, save_cnt);
        end
        press(1);
        checks++;
        if (run_a !== 1'b1) begin
            errors++;
            $display("FAIL resume_run got %b want 1", run_a);
        end
        checks++;
        if (int'(u_a.tick_cnt) !== save_cnt + 3) begin
            errors++;
            $display("FAIL resume_tick got %0d want %0d",
                     u_a.tick_cnt, save_cnt + 3);
        end
    endtask

    task automatic test_speed();
        int n;
        speed_btn = 5'b00100;
        gap(n);
        checks++;
        if (!u_a.step_pulse) begin
            errors++;
            $display("FAIL spd_first_pulse got none want pulse in 200");
        end
        gap(n);
        checks++;
        if (n !== 30) begin
            errors++;
            $display("FAIL spd_gap_k2 got %0d want 30", n);
        end
        speed_btn = 5'b00001;
        gap(n);
        checks++;
        if (n !== 30) begin
            errors++;
            $display("FAIL spd_gap_pending got %0d want 30", n);
        end
        gap(n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL spd_gap_k0 got %0d want 10", n);
        end
        speed_btn = 5'b00011;
        gap(n);
        gap(n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL spd_gap_multi got %0d want 10", n);
        end
        speed_btn = 5'b00000;
        gap(n);
        gap(n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL spd_gap_none got %0d want 10", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        logic [3:0] exp_p [7];
        int hi;
        exp_p = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                  4'b0010, 4'b0001, 4'b0010};
        press(1);
        press(0);
        checks++;
        if (mode_a !== 2'd1 || mode_b !== 2'd1) begin
            errors++;
            $display("FAIL bnc_mode got %0d/%0d want 1", mode_a, mode_b);
        end
        pattern_b(pat);
        checks++;
        if (pat !== 4'b0001) begin
            errors++;
            $display("FAIL bnc_preload got %b want 0001", pat);
        end
        measure_b(0, hi);
        checks++;
        if (hi !== 7) begin
            errors++;
            $display("FAIL bnc_full_b got %0d want 7", hi);
        end
        measure_a(0, hi);
        checks++;
        if (hi !== 63) begin
            errors++;
            $display("FAIL bnc_full_a got %0d want 63", hi);
        end
        for (int s = 0; s < 7; s++) begin
            press(2);
            pattern_b(pat);
            checks++;
            if (pat !== exp_p[s]) begin
                errors++;
                $display("FAIL bnc_step%0d got %b want %b", s, pat, exp_p[s]);
            end
        end
    endtask

    task automatic test_breathe();
        int exp_l [15];
        int hi;
        bit same;
        exp_l = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        press(0);
        checks++;
        if (mode_a !== 2'd2) begin
            errors++;
            $display("FAIL brt_mode got %0d want 2", mode_a);
        end
        for (int s = 0; s < 15; s++) begin
            press(2);
            hi = 0;
            same = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (led_b[0]) hi = hi + 1;
                if (led_b != 4'h0 && led_b != 4'hF) same = 1'b0;
                if (led_a != 16'h0 && led_a != 16'hFFFF) same = 1'b0;
            end
            @(posedge clk);
            #1;
            checks++;
            if (hi !== exp_l[s] || same !== 1'b1) begin
                errors++;
                $display("FAIL brt_step%0d got %0d same=%b want %0d same=1",
                         s, hi, same, exp_l[s]);
            end
        end
    endtask

    task automatic test_static_collision();
        logic [3:0] pat;
        int hi;
        press(0);
        checks++;
        if (mode_a !== 2'd3) begin
            errors++;
            $display("FAIL sta_mode got %0d want 3", mode_a);
        end
        press(2);
        measure_b(1, hi);
        checks++;
        if (hi !== 2) begin
            errors++;
            $display("FAIL sta_hold got %0d want 2", hi);
        end
        press(0);
        checks++;
        if (mode_a !== 2'd0) begin
            errors++;
            $display("FAIL col_rotate got %0d want 0", mode_a);
        end
        step_btn = 1'b1;
        @(posedge clk);
        #1;
        mode_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step_btn = 1'b0;
        mode_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mode_a !== 2'd1) begin
            errors++;
            $display("FAIL col_mode got %0d want 1", mode_a);
        end
        pattern_b(pat);
        checks++;
        if (pat !== 4'b0001) begin
            errors++;
            $display("FAIL col_pattern got %b want 0001", pat);
        end
        measure_a(0, hi);
        checks++;
        if (hi !== 63) begin
            errors++;
            $display("FAIL col_led0_a got %0d want 63", hi);
        end
    endtask

    task automatic test_reset_mid();
        press(1);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led_a !== 16'h0 || led_b !== 4'h0) begin
            errors++;
            $display("FAIL mid_rst_led got %h/%h want 0", led_a, led_b);
        end
        checks++;
        if (mode_a !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst_mode got %0d want 0", mode_a);
        end
        checks++;
        if (run_a !== 1'b1 || u_a.tick_cnt !== 24'd0) begin
            errors++;
            $display("FAIL mid_rst_tick got run=%b cnt=%0d want 1 0",
                     run_a, u_a.tick_cnt);
        end
        #5 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_pause_step();
        test_speed();
        test_bounce();
        test_breathe();
        test_static_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
